instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, is the sequential PC increment in bytes.
REQ-003 CLK  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 RESET  input  1  is the reset, synchronous and active-high.
REQ-005 PC  output  32  is the address of the instruction currently being fetched or issued.
REQ-006 IMEM_READ  output  1  is the instruction-memory read request.
REQ-007 IMEM_ADDRESS  output  32  is the instruction-memory address, always equal to PC.
REQ-008 IMEM_INSTRUCTION  input  32  is the instruction word returned by memory.
REQ-009 IMEM_BUSYWAIT  input  1  is high while memory has not yet returned valid data.
REQ-010 STALL  input  1  is high when the downstream decode/control stage cannot accept the issued instruction.
REQ-011 BRANCH_TAKEN  input  1  selects BRANCH_TARGET as the next PC.
REQ-012 BRANCH_TARGET  input  32  is the redirect address.
REQ-013 INSTR_VALID  output  1  is high when OPCODE/DEST/SRC1/SRC2 hold a valid instruction.
REQ-014 OPCODE  output  8  is instruction register bits [31:24], the control-unit opcode.
REQ-015 DEST  output  8  is IR bits [23:16], the destination register field.
REQ-016 SRC1  output  8  is IR bits [15:8], the first source register field.
REQ-017 SRC2  output  8  is IR bits [7:0], the second source register or immediate field.
REQ-018 ILLEGAL  output  1  flags an unsupported opcode (see Configuration).

Function
REQ-019 The FSM SHALL have three states: S_RESET, S_FETCH and S_ISSUE.
REQ-020 S_RESET SHALL move to S_FETCH on the first edge with RESET low.
REQ-021 IMEM_READ SHALL be 1 only in S_FETCH and SHALL be decoded from state alone.
REQ-022 In S_FETCH at an edge with IMEM_BUSYWAIT=0, IR SHALL load IMEM_INSTRUCTION and the state SHALL become S_ISSUE.
REQ-023 In S_FETCH at an edge with IMEM_BUSYWAIT=1, state, PC and IR SHALL hold.
REQ-024 INSTR_VALID SHALL be 1 only in S_ISSUE.
REQ-025 In S_ISSUE at an edge with STALL=0, PC SHALL load BRANCH_TAKEN ? {BRANCH_TARGET[31:2],2'b00} : PC+PC_STEP, and the state SHALL become S_FETCH.
REQ-026 In S_ISSUE at an edge with STALL=1, PC, IR and state SHALL hold, and BRANCH_TAKEN SHALL be ignored.
REQ-027 BRANCH_TAKEN and STALL SHALL be ignored outside S_ISSUE.
REQ-028 PC[1:0] SHALL always be 2'b00.
REQ-029 PC+PC_STEP SHALL wrap modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-030 Minimum latency SHALL be one cycle from the request to INSTR_VALID, and throughput SHALL be one instruction per two cycles when there is no busywait and no stall.
REQ-031 OPCODE/DEST/SRC1/SRC2 SHALL stay stable while INSTR_VALID=1.

Reset
REQ-032 An edge with RESET=1 SHALL set PC=RESET_PC, IR=32'h0, state=S_RESET, INSTR_VALID=0, IMEM_READ=0 and ILLEGAL=0, from any state.
REQ-033 RESET asserted during an outstanding fetch SHALL abandon it; data returned later SHALL be discarded.
REQ-034 Reset SHALL take priority over STALL, BRANCH_TAKEN and IMEM_BUSYWAIT.

Configuration
REQ-035 With macro FETCH_OPCODE_CHECK_EN defined, an IR load whose opcode is above 8'h05 SHALL set ILLEGAL=1 for that issue and SHALL present OPCODE=8'h01 (MOV) with DEST=SRC1=SRC2 = the fetched DEST.
REQ-036 With FETCH_OPCODE_CHECK_EN undefined, ILLEGAL SHALL be constant 0 and IR fields SHALL pass through unmodified.

Verification
REQ-037 Reset then IMEM_BUSYWAIT=0 with word 32'h0004_0005 -> next cycle INSTR_VALID=1, OPCODE=8'h00, DEST=8'h04, SRC2=8'h05, PC=0.
REQ-038 IMEM_BUSYWAIT held high for 3 cycles -> IMEM_READ=1 and PC constant for 3 cycles, INSTR_VALID=0 throughout, then issue on the 4th edge.
REQ-039 STALL=1 for 2 cycles in S_ISSUE with BRANCH_TAKEN=1 -> outputs held, no redirect; STALL=0 with BRANCH_TAKEN=1 and target 32'h0000_0043 -> PC=32'h0000_0040.
REQ-040 PC=32'hFFFF_FFFC issued with STALL=0 and no branch -> next PC=32'h0000_0000.
REQ-041 RESET=1 pulsed during S_FETCH with busywait high -> next cycle PC=RESET_PC, IMEM_READ=0, INSTR_VALID=0.
REQ-042 FETCH_OPCODE_CHECK_EN defined, word 32'h0902_0304 -> ILLEGAL=1, OPCODE=8'h01, DEST=SRC1=SRC2=8'h02; undefined -> OPCODE=8'h09, ILLEGAL=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory, pipeline-control and decoded-field signals of the fetch stage
interface instruction_fetch_if;
  logic [31:0] pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        imem_busywait;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [7:0]  opcode;
  logic [7:0]  dest;
  logic [7:0]  src1;
  logic [7:0]  src2;
  logic        illegal;
  modport master (
    input  imem_instruction, imem_busywait, stall, branch_taken, branch_target,
    output pc, imem_read, imem_address, instr_valid, opcode, dest, src1, src2, illegal
  );
  modport slave (
    output imem_instruction, imem_busywait, stall, branch_taken, branch_target,
    input  pc, imem_read, imem_address, instr_valid, opcode, dest, src1, src2, illegal
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: reset/fetch/issue FSM with PC, IR and field split.
// Optional macro FETCH_OPCODE_CHECK_EN replaces opcodes above 8'h05 with a flagged MOV.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input logic           clk,
  input logic           reset,
  instruction_fetch_if.master bus
);
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_ISSUE} state_t;
  state_t      state, next_state;
  logic [31:0] pc, ir, ir_load, pc_next;
  logic        load, advance;
  assign load    = state == S_FETCH && !bus.imem_busywait;
  assign advance = state == S_ISSUE && !bus.stall;
  always_comb begin
    next_state = state;
    next_state = state == S_RESET ? S_FETCH :
                 state == S_FETCH ? (bus.imem_busywait ? S_FETCH : S_ISSUE) :
                 (bus.stall ? S_ISSUE : S_FETCH);
  end
  always_ff @(posedge clk)
    state <= reset ? S_RESET : next_state;
  assign pc_next = bus.branch_taken ? (bus.branch_target & 32'hFFFF_FFFC)
                                    : (pc + 32'(PC_STEP)) & 32'hFFFF_FFFC;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC & 32'hFFFF_FFFC;
      ir <= 32'h0;
    end else begin
      if (load) ir <= ir_load;
      if (advance) pc <= pc_next;
    end
  end
`ifdef FETCH_OPCODE_CHECK_EN
  logic ill, ill_load;
  assign ill_load = bus.imem_instruction[31:24] > 8'h05;
  // unsupported opcodes become MOV dest,dest,dest so the datapath stays harmless
  assign ir_load  = ill_load ? {8'h01, {3{bus.imem_instruction[23:16]}}} : bus.imem_instruction;
  always_ff @(posedge clk) begin
    if (reset) ill <= 1'b0;
    else if (load) ill <= ill_load;
  end
  assign bus.illegal = ill && state == S_ISSUE;
`else
  assign ir_load     = bus.imem_instruction;
  assign bus.illegal = 1'b0;
`endif
  assign bus.pc           = pc;
  assign bus.imem_address = pc;
  assign bus.imem_read    = state == S_FETCH;
  assign bus.instr_valid  = state == S_ISSUE;
  assign bus.opcode       = ir[31:24];
  assign bus.dest         = ir[23:16];
  assign bus.src1         = ir[15:8];
  assign bus.src2         = ir[7:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven fetch/issue vectors with a scoreboard, plus reset corner sequences
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  instruction_fetch_if bus();
  instruction_fetch dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic [7:0]  op, d, s1, s2;
    logic        ill;
  } exp_t;
  typedef struct {
    logic [31:0] word;
    int          busy;
    int          stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] issue_pc;
    logic [31:0] next_pc;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic exp_t decode(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    e.pc = pc; e.op = w[31:24]; e.d = w[23:16]; e.s1 = w[15:8]; e.s2 = w[7:0]; e.ill = 1'b0;
`ifdef FETCH_OPCODE_CHECK_EN
    if (w[31:24] > 8'h05) begin
      e.op = 8'h01; e.s1 = w[23:16]; e.s2 = w[23:16]; e.ill = 1'b1;
    end
`endif
    return e;
  endfunction
  task automatic check_issue(input string tag, input exp_t e);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_read"}, 32'(bus.imem_read), 32'd0);
    chk({tag, "_pc"}, bus.pc, e.pc);
    chk({tag, "_addr"}, bus.imem_address, e.pc);
    chk({tag, "_opcode"}, 32'(bus.opcode), 32'(e.op));
    chk({tag, "_dest"}, 32'(bus.dest), 32'(e.d));
    chk({tag, "_src1"}, 32'(bus.src1), 32'(e.s1));
    chk({tag, "_src2"}, 32'(bus.src2), 32'(e.s2));
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'(e.ill));
  endtask
  task automatic pop_issue(input string tag, output exp_t e);
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s_scoreboard: got empty queue expected an entry", tag);
      e = '{pc: 32'h0, op: 8'h0, d: 8'h0, s1: 8'h0, s2: 8'h0, ill: 1'b0};
    end else begin
      e = sb.pop_front();
      check_issue(tag, e);
    end
  endtask
  task automatic run_vec(input vec_t v);
    exp_t e;
    chk("fetch_read", 32'(bus.imem_read), 32'd1);
    chk("fetch_pc", bus.pc, v.issue_pc);
    for (int i = 0; i < v.busy; i++) begin
      bus.imem_busywait = 1'b1;
      bus.imem_instruction = $urandom;
      bus.stall = 1'($urandom);
      bus.branch_taken = 1'b1;
      bus.branch_target = $urandom;
      @(negedge clk);
      chk("busy_read", 32'(bus.imem_read), 32'd1);
      chk("busy_valid", 32'(bus.instr_valid), 32'd0);
      chk("busy_pc", bus.pc, v.issue_pc);
    end
    bus.imem_busywait = 1'b0;
    bus.imem_instruction = v.word;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    sb.push_back(decode(v.issue_pc, v.word));
    @(negedge clk);
    pop_issue("issue", e);
    bus.imem_busywait = 1'($urandom);
    bus.imem_instruction = $urandom;
    for (int i = 0; i < v.stall; i++) begin
      bus.stall = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_target = $urandom;
      @(negedge clk);
      check_issue("stall", e);
    end
    bus.stall = 1'b0;
    bus.branch_taken = v.br;
    bus.branch_target = v.tgt;
    @(negedge clk);
    chk("next_pc", bus.pc, v.next_pc);
    chk("next_read", 32'(bus.imem_read), 32'd1);
    chk("next_valid", 32'(bus.instr_valid), 32'd0);
    bus.branch_taken = 1'b0;
  endtask
  initial begin
    exp_t e;
    vecs[0] = '{32'h0004_0005, 0, 0, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{32'h0102_0304, 3, 0, 1'b1, 32'h0000_0100, 32'h0000_0004, 32'h0000_0100};
    vecs[2] = '{32'h0211_2233, 0, 2, 1'b1, 32'h0000_0043, 32'h0000_0100, 32'h0000_0040};
    vecs[3] = '{32'h0902_0304, 1, 1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0040, 32'hFFFF_FFFC};
    vecs[4] = '{32'h05AA_BBCC, 0, 0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000};
    vecs[5] = '{32'h06FF_0102, 2, 0, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004};
    reset = 1'b1;
    bus.imem_instruction = 32'h0;
    bus.imem_busywait = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_read", 32'(bus.imem_read), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_opcode", 32'(bus.opcode), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    bus.imem_busywait = 1'b1;
    @(negedge clk);
    chk("abandon_pre_read", 32'(bus.imem_read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abandon_pc", bus.pc, 32'h0);
    chk("abandon_read", 32'(bus.imem_read), 32'd0);
    chk("abandon_valid", 32'(bus.instr_valid), 32'd0);
    reset = 1'b0;
    bus.imem_busywait = 1'b0;
    bus.imem_instruction = 32'h0304_0506;
    @(negedge clk);
    chk("discard_read", 32'(bus.imem_read), 32'd1);
    chk("discard_valid", 32'(bus.instr_valid), 32'd0);
    bus.imem_instruction = 32'h0A01_0203;
    sb.push_back(decode(32'h0, 32'h0A01_0203));
    @(negedge clk);
    pop_issue("after_rst", e);
`ifdef FETCH_OPCODE_CHECK_EN
    chk("cfg_opcode", 32'(bus.opcode), 32'h01);
`else
    chk("cfg_opcode", 32'(bus.opcode), 32'h0A);
`endif
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h0000_0800;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_issue_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_issue_read", 32'(bus.imem_read), 32'd0);
    chk("rst_issue_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_issue_opcode", 32'(bus.opcode), 32'd0);
    chk("rst_issue_pc", bus.pc, 32'h0);
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    @(negedge clk);
    chk("rst_issue_refetch", 32'(bus.imem_read), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
